// File: rtl/wb_writer.sv
// Writeback driver for the regfile write port: ALU results first, then queued LSU results.
// Optional WB_STARVE_GUARD_EN adds a starvation counter that requests a one-cycle ALU stall.
module wb_writer #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_alu_valid,
  input  logic [ADDR_W-1:0]               i_alu_addr,
  input  logic [DATA_W-1:0]               i_alu_data,
  input  logic                            i_lsu_valid,
  output logic                            o_lsu_ready,
  input  logic [ADDR_W-1:0]               i_lsu_addr,
  input  logic [DATA_W-1:0]               i_lsu_data,
  output logic                            o_wreg_en,
  output logic [ADDR_W-1:0]               o_wreg_addr,
  output logic [DATA_W-1:0]               o_wreg_data,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   o_q_count,
  output logic                            o_alu_stall
);
  localparam int CW = $clog2(LQ_DEPTH+1);
  localparam int PW = $clog2(LQ_DEPTH);

  logic [ADDR_W-1:0] mem_addr_q [LQ_DEPTH];
  logic [DATA_W-1:0] mem_data_q [LQ_DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wreg_en_q, wreg_en_d;
  logic [ADDR_W-1:0] wreg_addr_q, wreg_addr_d;
  logic [DATA_W-1:0] wreg_data_q, wreg_data_d;

  logic              hs, push, pop, sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Ready deliberately ignores a same-cycle pop: no push-through when full.
  assign o_lsu_ready = (count_q != CW'(LQ_DEPTH));
  assign hs          = i_lsu_valid && o_lsu_ready;

  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    sel      = 1'b0;
    sel_addr = i_alu_addr;
    sel_data = i_alu_data;
    if (i_alu_valid) begin
      sel  = 1'b1;
      push = hs;
    end else if (count_q != '0) begin
      sel      = 1'b1;
      pop      = 1'b1;
      sel_addr = mem_addr_q[rd_ptr_q];
      sel_data = mem_data_q[rd_ptr_q];
      push     = hs;
    end else if (hs) begin
      sel      = 1'b1;
      sel_addr = i_lsu_addr;
      sel_data = i_lsu_data;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // x0 writes are consumed silently; an idle cycle holds addr/data.
    wreg_en_d   = sel && (sel_addr != '0);
    wreg_addr_d = sel ? sel_addr : wreg_addr_q;
    wreg_data_d = sel ? sel_data : wreg_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wreg_en_q   <= 1'b0;
      wreg_addr_q <= '0;
      wreg_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wreg_en_q   <= wreg_en_d;
      wreg_addr_q <= wreg_addr_d;
      wreg_data_q <= wreg_data_d;
    end
  end

  // Storage has no reset; the cleared pointers make old entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= i_lsu_addr;
      mem_data_q[wr_ptr_q] <= i_lsu_data;
    end
  end

  assign o_wreg_en   = wreg_en_q;
  assign o_wreg_addr = wreg_addr_q;
  assign o_wreg_data = wreg_data_q;
  assign o_q_count   = count_q;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if ((count_q != '0) && i_alu_valid) begin
      if (starve_q == SW'(STARVE_LIMIT-1)) stall_d = 1'b1;
      else                                 starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign o_alu_stall = stall_q;
`else
  wire unused_starve_limit = |STARVE_LIMIT;
  assign o_alu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: per-cycle vector table with a scoreboard of expected
// writeback state, plus a hand-written starvation sequence.
module tb_wb_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_addr;
  logic [31:0] i_lsu_data;
  logic        o_wreg_en;
  logic [4:0]  o_wreg_addr;
  logic [31:0] o_wreg_data;
  logic [2:0]  o_q_count;
  logic        o_alu_stall;

  wb_writer #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_alu_valid(i_alu_valid), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
    .i_lsu_addr(i_lsu_addr), .i_lsu_data(i_lsu_data),
    .o_wreg_en(o_wreg_en), .o_wreg_addr(o_wreg_addr), .o_wreg_data(o_wreg_data),
    .o_q_count(o_q_count), .o_alu_stall(o_alu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rdy;   // o_lsu_ready before the edge
    logic        en;    // outputs after the edge
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        stall;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                             logic lv, logic [4:0] la, logic [31:0] ld,
                             logic rdy, logic en, logic [4:0] wa, logic [31:0] wd,
                             logic [2:0] cnt);
    vec_t x;
    x.rst = r; x.av = av; x.aa = aa; x.ad = ad; x.lv = lv; x.la = la; x.ld = ld;
    x.rdy = rdy; x.en = en; x.wa = wa; x.wd = wd; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    rst = r; i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
  endtask

  // Expected state is queued at drive time and retired one edge later.
  task automatic clock_and_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".en"},    32'(o_wreg_en),   32'(e.en));
    chk({tag, ".addr"},  32'(o_wreg_addr), 32'(e.wa));
    chk({tag, ".data"},  o_wreg_data,      e.wd);
    chk({tag, ".count"}, 32'(o_q_count),   32'(e.cnt));
    chk({tag, ".stall"}, 32'(o_alu_stall), 32'(e.stall));
  endtask

  initial begin
    exp_t e;
    logic stall_exp;

    // reset / ALU / bypass / idle hold
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0,            0));
    tbl.push_back(v(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0,        1, 1, 5, 32'hA5A5A5A5, 0));
    tbl.push_back(v(1, 0, 0, 0,            1, 3, 32'h11,   1, 1, 3, 32'h11,       0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 3, 32'h11,       0));
    // ALU busy 6 cycles while LSU offers 5; queue fills at 4
    tbl.push_back(v(1, 1, 1, 32'h101,      1, 10, 32'h20A, 1, 1, 1, 32'h101,      1));
    tbl.push_back(v(1, 1, 2, 32'h102,      1, 11, 32'h20B, 1, 1, 2, 32'h102,      2));
    tbl.push_back(v(1, 1, 3, 32'h103,      1, 12, 32'h20C, 1, 1, 3, 32'h103,      3));
    tbl.push_back(v(1, 1, 4, 32'h104,      1, 13, 32'h20D, 1, 1, 4, 32'h104,      4));
    tbl.push_back(v(1, 1, 5, 32'h105,      1, 14, 32'h20E, 0, 1, 5, 32'h105,      4));
    tbl.push_back(v(1, 1, 6, 32'h106,      1, 14, 32'h20E, 0, 1, 6, 32'h106,      4));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        0, 1, 10, 32'h20A,     3));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 1, 11, 32'h20B,     2));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 1, 12, 32'h20C,     1));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 1, 13, 32'h20D,     0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 13, 32'h20D,     0));
    // x0 writes from both sources are consumed without enable
    tbl.push_back(v(1, 1, 0, 32'hFFFF,     1, 0, 32'h33,   1, 0, 0, 32'hFFFF,     1));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 0, 32'h33,       0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 0, 32'h33,       0));
    // two queued, then reset discards them
    tbl.push_back(v(1, 1, 7, 32'h107,      1, 15, 32'h301, 1, 1, 7, 32'h107,      1));
    tbl.push_back(v(1, 1, 8, 32'h108,      1, 16, 32'h302, 1, 1, 8, 32'h108,      2));
    tbl.push_back(v(0, 1, 9, 32'h109,      1, 17, 32'h303, 1, 0, 0, 0,            0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0,            0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0,            0));
    // simultaneous push/pop across the pointer wrap
    tbl.push_back(v(1, 1, 1, 32'h111,      1, 18, 32'h304, 1, 1, 1, 32'h111,      1));
    tbl.push_back(v(1, 0, 0, 0,            1, 19, 32'h305, 1, 1, 18, 32'h304,     1));
    tbl.push_back(v(1, 0, 0, 0,            1, 20, 32'h306, 1, 1, 19, 32'h305,     1));
    tbl.push_back(v(1, 0, 0, 0,            1, 21, 32'h307, 1, 1, 20, 32'h306,     1));
    tbl.push_back(v(1, 0, 0, 0,            1, 22, 32'h308, 1, 1, 21, 32'h307,     1));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 1, 22, 32'h308,     0));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        1, 0, 22, 32'h308,     0));

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
      e.en = tbl[i].en; e.wa = tbl[i].wa; e.wd = tbl[i].wd; e.cnt = tbl[i].cnt; e.stall = 1'b0;
      sb.push_back(e);
      #1;
      if (tbl[i].rst) chk($sformatf("v%0d.ready", i), 32'(o_lsu_ready), 32'(tbl[i].rdy));
      clock_and_check($sformatf("v%0d", i));
    end

    // Starvation: one entry queued, ALU never lets go until the stall pulse.
    drive(1, 1, 2, 32'h200, 1, 9, 32'h9999);
    e.en = 1; e.wa = 2; e.wd = 32'h200; e.cnt = 1; e.stall = 0;
    sb.push_back(e);
    clock_and_check("st.push");
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 5'(k), 32'h400 + 32'(k), 0, 0, 0);
`ifdef WB_STARVE_GUARD_EN
      stall_exp = (k == 8);
`else
      stall_exp = 1'b0;
`endif
      e.en = 1; e.wa = 5'(k); e.wd = 32'h400 + 32'(k); e.cnt = 1; e.stall = stall_exp;
      sb.push_back(e);
      clock_and_check($sformatf("st.c%0d", k));
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    e.en = 1; e.wa = 9; e.wd = 32'h9999; e.cnt = 0; e.stall = 0;
    sb.push_back(e);
    clock_and_check("st.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
